regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port arbiter and pending-write scoreboard for the CPU's 8-entry register file (r0..r7). Two writeback sources, the ALU (A) and the load unit (B), compete for the single register-file write port. The block grants one write per cycle round-robin and drives a registered write port. It also tracks registers with an outstanding write, so the decode stage can stall on read-after-write and write-after-write hazards.

## Interface
- DATA_W, 8, width of register data
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- a_valid  in  1  ALU writeback request
- a_reg  in  4  ALU target register (register-name encoding: NONE=0, r0=1 .. r7=8)
- a_data  in  DATA_W  ALU writeback data
- a_ready  out  1  ALU request accepted this cycle (combinational)
- b_valid, b_reg, b_data, b_ready  same as A, for the load unit
- wr_en  out  1  register-file write strobe (registered)
- wr_reg  out  4  register-file write target, register-name encoding (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- issue_valid  in  1  decode issues an instruction that will write issue_reg
- issue_reg  in  4  destination of the issued instruction
- issue_ready  out  1  issue accepted (combinational)
- q0_reg, q1_reg  in  4  source registers queried by decode
- q0_hazard, q1_hazard  out  1  the queried register has a write in flight (combinational)
- busy  out  8  pending-write bit per register, bit i corresponds to r_i
- pending  out  4  number of set busy bits, 0..8

## Operation
- Codes 9..15 on any register input are treated as NONE.
- NONE-target requests:
  - A request with a NONE target is accepted immediately (ready=1).
  - It does not use the write port, does not touch any state and does not move the round-robin pointer.
- Real-target requests:
  - If only one requester is valid, it is granted.
  - If both are valid, the grant goes to the requester that did not win the last contested cycle.
  - The pointer `last` (0=A, 1=B) updates only on contested cycles. Its reset value is 1, so A wins the first conflict.
- Ready rules:
  - The non-granted requester sees ready=0 and must hold valid, reg and data stable until it gets ready.
  - If both requesters target the same register, they are still serialized by round-robin.
- Scoreboard:
  - issue_ready = !busy[issue_reg] for a real target. For a NONE target, issue_ready=1 and nothing is recorded.
  - On an accepted issue, busy[issue_reg] sets at the next edge.
  - On an accepted writeback to register r, busy[r] clears at the next edge.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - A writeback to a register whose busy bit is already 0 is legal. The write is performed and busy stays 0.
- Hazard query:
  - qN_hazard = busy[qN_reg] | (wr_en & wr_reg==qN_reg).
  - So a reader stalls until the register-file write cycle has completed.
  - NONE queries always return 0.
- pending is the population count of busy, registered alongside busy.

## Timing
- Reset values: wr_en=0, wr_reg=NONE, wr_data=0, busy=0, pending=0, last=1.
- Reset and requests:
  - While reset is high, a_ready, b_ready and issue_ready are 0.
  - Reset asserted mid-operation drops any in-flight grant and write, with no write in the cycle after reset.
- Latency: a request accepted in cycle N produces wr_en=1 with its reg and data in cycle N+1. The throughput is one write per cycle.
- wr_en is 0 in any cycle after one in which no real-target request was accepted.
- Busy-bit timing: an issue in cycle N gives busy=1 from cycle N+1, and a writeback accepted in cycle M gives busy=0 from M+1. In cycle M+1 the hazard stays 1 through the wr_en term; it drops in cycle M+2.
- Maximum wait for a continuously valid requester is 1 cycle.
- Full condition: pending=8 when all registers are busy. Further real issues see issue_ready=0.
- Empty condition: pending=0.

## Test plan
- Reset, then A writes r3=0x5A in cycle 1:
  - a_ready=1 in cycle 1.
  - wr_en=1, wr_reg=4, wr_data=0x5A in cycle 2.
  - wr_en=0 in cycle 3.
- Contention, with A and B valid continuously for 4 cycles (A→r1=0x11, B→r2=0x22):
  - Grants go A, B, A, B.
  - The wr_reg sequence is 2, 3, 2, 3, each write one cycle after its grant.
- NONE bypass, with A→NONE and B→r5 in the same cycle:
  - Both readies are 1.
  - A single write to r5 follows, and `last` is unchanged.
- Scoreboard, issue r7 in cycle 1:
  - busy[7]=1 and pending=1 in cycle 2.
  - A second issue r7 sees issue_ready=0.
  - When B writes r7 in cycle 5, q0_hazard (q0_reg=8) stays 1 through cycle 6 and is 0 in cycle 7.
- Same-cycle set and clear, with issue r2 while A writes r2:
  - busy[2]=1 afterwards.
  - Issue all 8 registers: pending=8 and every real issue_ready=0.
- Reset mid-operation, with reset asserted in the cycle a request is accepted:
  - wr_en=0 in the next cycle.
  - busy=0 and pending=0.
  - Both readies are 0 while reset is high.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write-port arbiter and pending-write scoreboard
// Two writeback sources share one registered register-file write port; busy bits track in-flight writes.
module regfile_wr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [3:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [3:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [3:0]        wr_reg,
    output logic [DATA_W-1:0] wr_data,
    input  logic              issue_valid,
    input  logic [3:0]        issue_reg,
    output logic              issue_ready,
    input  logic [3:0]        q0_reg,
    input  logic [3:0]        q1_reg,
    output logic              q0_hazard,
    output logic              q1_hazard,
    output logic [7:0]        busy,
    output logic [3:0]        pending
);

    // Register-name encoding: 1..8 name r0..r7, everything else is NONE.
    function automatic logic is_real(input logic [3:0] code);
        return (code != 4'd0) && (code <= 4'd8);
    endfunction

    function automatic logic [2:0] reg_idx(input logic [3:0] code);
        return 3'(code - 4'd1);
    endfunction

    logic              wr_en_q, wr_en_d;
    logic [3:0]        wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [7:0]        busy_q, busy_d;
    logic [3:0]        pending_q, pending_d;
    logic              last_q, last_d;

    logic a_real, b_real, issue_real;
    logic grant_a, grant_b;
    logic [7:0] clr_mask, set_mask;

    always_comb begin
        a_real     = a_valid & is_real(a_reg);
        b_real     = b_valid & is_real(b_reg);
        issue_real = is_real(issue_reg);

        // last_q=1 means B won the previous contest, so A takes the next one.
        grant_a = ~reset & a_real & (~b_real | last_q);
        grant_b = ~reset & b_real & (~a_real | ~last_q);

        a_ready     = ~reset & (~a_real | grant_a);
        b_ready     = ~reset & (~b_real | grant_b);
        issue_ready = ~reset & (~issue_real | ~busy_q[reg_idx(issue_reg)]);

        clr_mask = 8'd0;
        if (grant_a) clr_mask[reg_idx(a_reg)] = 1'b1;
        if (grant_b) clr_mask[reg_idx(b_reg)] = 1'b1;
        set_mask = 8'd0;
        if (issue_valid & issue_real & issue_ready) set_mask[reg_idx(issue_reg)] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;

        pending_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pending_d = pending_d + {3'd0, busy_d[i]};
        end

        wr_en_d   = grant_a | grant_b;
        wr_reg_d  = 4'd0;
        wr_data_d = wr_data_q;
        if (grant_a) begin
            wr_reg_d  = a_reg;
            wr_data_d = a_data;
        end else if (grant_b) begin
            wr_reg_d  = b_reg;
            wr_data_d = b_data;
        end

        last_d = (a_real & b_real) ? grant_b : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= 4'd0;
            wr_data_q <= '0;
            busy_q    <= 8'd0;
            pending_q <= 4'd0;
            last_q    <= 1'b1;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            last_q    <= last_d;
        end
    end

    // The wr_en term keeps readers stalled through the cycle the register file is written.
    assign q0_hazard = is_real(q0_reg) & (busy_q[reg_idx(q0_reg)] | (wr_en_q & (wr_reg_q == q0_reg)));
    assign q1_hazard = is_real(q1_reg) & (busy_q[reg_idx(q1_reg)] | (wr_en_q & (wr_reg_q == q1_reg)));

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - randomized bench with a behavioural scoreboard model
module tb_regfile_wr_arbiter;

    logic       clk, reset;
    logic       a_valid, b_valid, issue_valid;
    logic [3:0] a_reg, b_reg, issue_reg, q0_reg, q1_reg;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, issue_ready, wr_en, q0_hazard, q1_hazard;
    logic [3:0] wr_reg, pending;
    logic [7:0] wr_data, busy;

    regfile_wr_arbiter #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .q0_reg(q0_reg), .q1_reg(q1_reg), .q0_hazard(q0_hazard), .q1_hazard(q1_hazard),
        .busy(busy), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: which registers are waiting, who won last, what is being written now.
    bit [7:0] m_busy;
    bit       m_last_b;
    bit       m_wr_en;
    int       m_wr_reg;
    int       m_wr_data;
    bit       a_acc, b_acc;

    function automatic bit named(input int code);
        return code >= 1 && code <= 8;
    endfunction

    function automatic bit exp_hazard(input int q);
        if (!named(q)) return 0;
        return m_busy[q-1] || (m_wr_en && m_wr_reg == q);
    endfunction

    // Called at posedge+1 with inputs set; checks this cycle, then advances to posedge+1 of the next.
    task automatic tick();
        bit ar, br, ga, gb, ea, eb, ei;
        bit [7:0] nb;
        int ir;
        #1;
        ar = a_valid && named(int'(a_reg));
        br = b_valid && named(int'(b_reg));
        ir = int'(issue_reg);
        if (reset) begin
            ga = 0; gb = 0; ea = 0; eb = 0; ei = 0;
        end else begin
            if (ar && br) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = ar;
                gb = br;
            end
            ea = !ar || ga;
            eb = !br || gb;
            ei = !named(ir) || !m_busy[ir-1];
        end
        check("a_ready", 32'(a_ready), 32'(ea));
        check("b_ready", 32'(b_ready), 32'(eb));
        check("issue_ready", 32'(issue_ready), 32'(ei));
        check("q0_hazard", 32'(q0_hazard), 32'(exp_hazard(int'(q0_reg))));
        check("q1_hazard", 32'(q1_hazard), 32'(exp_hazard(int'(q1_reg))));
        check("wr_en", 32'(wr_en), 32'(m_wr_en));
        check("busy", 32'(busy), 32'(m_busy));
        check("pending", 32'(pending), 32'($countones(m_busy)));
        if (m_wr_en) begin
            check("wr_reg", 32'(wr_reg), 32'(m_wr_reg));
            check("wr_data", 32'(wr_data), 32'(m_wr_data));
        end
        a_acc = a_valid && ea;
        b_acc = b_valid && eb;
        if (reset) begin
            nb = '0;
            m_last_b = 1;
            m_wr_en = 0;
            m_wr_reg = 0;
            m_wr_data = 0;
        end else begin
            nb = m_busy;
            if (ga) nb[a_reg-1] = 0;
            if (gb) nb[b_reg-1] = 0;
            if (issue_valid && named(ir) && ei) nb[ir-1] = 1;
            if (ar && br) m_last_b = gb;
            m_wr_en = ga || gb;
            m_wr_reg = ga ? int'(a_reg) : int'(b_reg);
            m_wr_data = ga ? int'(a_data) : int'(b_data);
        end
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; issue_valid = 0;
        a_reg = 0; b_reg = 0; issue_reg = 0;
        a_data = 0; b_data = 0; q0_reg = 0; q1_reg = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        m_busy = '0; m_last_b = 1; m_wr_en = 0; m_wr_reg = 0; m_wr_data = 0;
        @(posedge clk);
        #1;
        tick();
        reset = 0;
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);

        // A writes r3=0x5A, then idle
        a_valid = 1; a_reg = 4; a_data = 8'h5A;
        tick();
        idle();
        check("first_wr_reg", 32'(wr_reg), 32'd4);
        tick();
        tick();

        // Contention A->r1, B->r2 for four cycles, accepted requester stays valid
        a_valid = 1; a_reg = 2; a_data = 8'h11;
        b_valid = 1; b_reg = 3; b_data = 8'h22;
        for (int i = 0; i < 4; i++) tick();
        idle();
        tick();

        // NONE bypass: A->NONE with B->r5
        a_valid = 1; a_reg = 0; b_valid = 1; b_reg = 6; b_data = 8'h55;
        tick();
        idle();
        tick();

        // Scoreboard on r7, second issue refused, writeback with hazard tail
        issue_valid = 1; issue_reg = 8;
        tick();
        tick();
        idle();
        q0_reg = 8;
        tick();
        b_valid = 1; b_reg = 8; b_data = 8'h77;
        tick();
        b_valid = 0;
        tick();
        tick();

        // Same-cycle set and clear on r2, then fill every register
        issue_valid = 1; issue_reg = 3; a_valid = 1; a_reg = 3; a_data = 8'h33;
        tick();
        idle();
        for (int r = 1; r <= 8; r++) begin
            issue_valid = 1; issue_reg = 4'(r);
            tick();
        end
        idle();
        check("full_pending", 32'(pending), 32'd8);
        for (int r = 1; r <= 8; r++) begin
            issue_valid = 1; issue_reg = 4'(r);
            tick();
        end
        idle();

        // Reset in the cycle a request is accepted
        a_valid = 1; a_reg = 2; a_data = 8'h99;
        tick();
        reset = 1;
        tick();
        reset = 0;
        idle();
        check("post_rst_busy", 32'(busy), 32'd0);
        tick();

        // Random traffic; a refused requester holds its request
        for (int c = 0; c < 3000; c++) begin
            if (!a_valid || a_acc) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_reg   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
                a_data  = 8'($urandom);
            end
            if (!b_valid || b_acc) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_reg   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
                b_data  = 8'($urandom);
            end
            issue_valid = ($urandom_range(0, 1) != 0);
            issue_reg   = 4'($urandom_range(0, 15));
            q0_reg      = 4'($urandom_range(0, 15));
            q1_reg      = 4'($urandom_range(0, 15));
            reset       = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
